// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the load/store path: funct3 width codes, LSU state
// encoding and the request legality check.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_RD   = 2'd1,
        LSU_WR   = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_t;

    // Unsigned widths exist only for loads; halves and words must be naturally aligned.
    function automatic logic req_fault(input logic is_load, input logic [2:0] f3,
                                       input logic [1:0] lo);
        logic legal;
        legal = 1'b0;
        case (f3)
            F3_B:    legal = 1'b1;
            F3_H:    legal = !lo[0];
            F3_W:    legal = (lo == 2'b00);
            F3_BU:   legal = is_load;
            F3_HU:   legal = is_load && !lo[0];
            default: legal = 1'b0;
        endcase
        return !legal;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: extracts and extends the load lane from a memory
// word, and merges the store lane into a word for read-modify-write.
module lsu_lane_align
    import rv32_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      byte_sel,
    input  logic [XLEN-1:0] rdata,
    input  logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] load_value,
    output logic [XLEN-1:0] merged
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      byte_val;
    logic [15:0]     half_val;

    always_comb begin
        shifted  = rdata >> {byte_sel, 3'b000};
        byte_val = shifted[7:0];
        half_val = byte_sel[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    load_value = {{24{byte_val[7]}}, byte_val};
            F3_H:    load_value = {{16{half_val[15]}}, half_val};
            F3_BU:   load_value = {24'd0, byte_val};
            F3_HU:   load_value = {16'd0, half_val};
            default: load_value = rdata;
        endcase

        merged = rdata;
        case (funct3)
            F3_B: merged[{byte_sel, 3'b000} +: 8] = store_data[7:0];
            F3_H: begin
                if (byte_sel[1]) merged[31:16] = store_data[15:0];
                else             merged[15:0]  = store_data[15:0];
            end
            default: merged = store_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns RV32 byte/half/word accesses into word-only
// Data_Memory handshakes, stalling the pipeline while each handshake is in flight.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   store_data,
    output logic [XLEN-1:0]   load_data,
    output logic              stall,
    output logic              addr_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_busywait
);

    lsu_state_t      state_reg;
    logic            issued_reg;
    logic            is_load_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      byte_sel_reg;
    logic [XLEN-1:0] store_data_reg;

    logic            req;
    logic            fault;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] merged;
    logic            addr_high_unused;

    // Address bits above the word index are dropped so accesses wrap silently.
    assign addr_high_unused = ^addr[XLEN-1:ADDR_W+2];

    assign req   = req_load | req_store;
    assign fault = req_fault(req_load, funct3, addr[1:0]);
    assign stall = ((state_reg == LSU_IDLE) && req && !fault)
                 || (state_reg == LSU_RD) || (state_reg == LSU_WR);

    lsu_lane_align u_lane_align (
        .funct3     (funct3_reg),
        .byte_sel   (byte_sel_reg),
        .rdata      (mem_rdata),
        .store_data (store_data_reg),
        .load_value (load_value),
        .merged     (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= LSU_IDLE;
            issued_reg     <= 1'b0;
            is_load_reg    <= 1'b0;
            funct3_reg     <= 3'd0;
            byte_sel_reg   <= 2'd0;
            store_data_reg <= '0;
            load_data      <= '0;
            addr_fault     <= 1'b0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_address    <= '0;
            mem_wdata      <= '0;
        end else begin
            addr_fault <= 1'b0;
            case (state_reg)
                LSU_IDLE: begin
                    if (req && fault) begin
                        addr_fault <= 1'b1;
                    end else if (req) begin
                        is_load_reg    <= req_load;
                        funct3_reg     <= funct3;
                        byte_sel_reg   <= addr[1:0];
                        store_data_reg <= store_data;
                        mem_address    <= addr[ADDR_W+1:2];
                        issued_reg     <= 1'b0;
                        // Only a full-word store can skip the read half of read-modify-write.
                        if (!req_load && funct3 == F3_W) begin
                            mem_write <= 1'b1;
                            mem_wdata <= store_data;
                            state_reg <= LSU_WR;
                        end else begin
                            mem_read  <= 1'b1;
                            state_reg <= LSU_RD;
                        end
                    end
                end
                LSU_RD: begin
                    if (!issued_reg) begin
                        issued_reg <= 1'b1;
                    end else if (!mem_busywait) begin
                        mem_read   <= 1'b0;
                        issued_reg <= 1'b0;
                        if (is_load_reg) begin
                            load_data <= load_value;
                            state_reg <= LSU_DONE;
                        end else begin
                            mem_write <= 1'b1;
                            mem_wdata <= merged;
                            state_reg <= LSU_WR;
                        end
                    end
                end
                LSU_WR: begin
                    if (!issued_reg) begin
                        issued_reg <= 1'b1;
                    end else if (!mem_busywait) begin
                        mem_write  <= 1'b0;
                        issued_reg <= 1'b0;
                        state_reg  <= LSU_DONE;
                    end
                end
                default: state_reg <= LSU_IDLE;
            endcase
        end
    end

endmodule
